cim_result_writeback: RTL and testbench
=======================================

CIM_RESULT_WRITEBACK -- requirements
Module: cim_result_writeback

Interface
REQ-001 SHALL have parameter CIM_LAT, default 1: cycles from output_reg change to valid cim_output (range 1..4).
REQ-002 SHALL have parameter MAX_REGS, default 16: number of CIM output registers addressable by 4-bit output_reg.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 start  input  1  one-cycle request to begin a writeback job.
REQ-006 base_addr  input  32  RAM byte address for the first word; sampled with start.
REQ-007 num_regs  input  5  number of output registers to write (0..16); sampled with start.
REQ-008 clear_after  input  1  when high at start, pulse reset_output after the last write.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse at job completion.
REQ-011 output_reg  output  4  CIM output register select.
REQ-012 cim_output  input  32  CIM output data for the selected register.
REQ-013 reset_output  output  1  one-cycle CIM output-clear pulse.
REQ-014 mem_addr  output  32  RAM write address.
REQ-015 mem_wdata  output  32  RAM write data.
REQ-016 mem_we  output  1  RAM write request.
REQ-017 mem_be  output  4  byte enables; 4'b1111 whenever mem_we is high, else 0.
REQ-018 mem_ready  input  1  RAM accepts the write in any cycle where mem_we and mem_ready are both high.

Function
REQ-019 FSM states SHALL be IDLE, SEL, WRITE, CLEAR, FIN.
REQ-020 IDLE: start high SHALL latch base_addr, min(num_regs,16), clear_after; set index 0; go to SEL (or FIN if count 0).
REQ-021 start while not IDLE SHALL be ignored with no effect on the current job.
REQ-022 SEL: output_reg SHALL equal index; after exactly CIM_LAT cycles in SEL, cim_output SHALL be captured into mem_wdata and FSM goes to WRITE.
REQ-023 WRITE: mem_we high; mem_addr = base + 4*index (modulo 2^32, wrap permitted); addr/data SHALL be held stable while mem_ready low.
REQ-024 On accepted write: index+1; if index+1 < count go to SEL, else go to CLEAR if clear_after latched, else FIN.
REQ-025 CLEAR: reset_output SHALL be high for exactly one cycle, then FIN.
REQ-026 FIN: done high for one cycle, busy low from the following cycle, return to IDLE; a new start SHALL be accepted in the cycle after done.
REQ-027 Minimum latency per word with mem_ready tied high: CIM_LAT+1 cycles; job latency start-to-done = count*(CIM_LAT+1)+1 (+1 with clear).
REQ-028 num_regs > 16 SHALL saturate to 16; num_regs = 0 SHALL produce done with no write and no reset_output.
REQ-029 mem_we, reset_output and done SHALL never be asserted simultaneously.
REQ-030 output_reg SHALL hold its last value outside SEL/WRITE.

Reset
REQ-031 rst_n low SHALL force IDLE; busy, done, mem_we, reset_output = 0; mem_be, output_reg = 0; mem_addr, mem_wdata = 0.
REQ-032 Reset mid-job SHALL abort immediately: no further writes, no done, no reset_output; the write in progress is not completed.

Verification
REQ-033 base 32768, num_regs 8, mem_ready=1, CIM_LAT 1, cim_output = 0x100+sel -> 8 writes to 32768..32796 data 0x100..0x107, done at cycle 17 after start.
REQ-034 Same job, mem_ready low for 3 cycles on the 3rd write -> addr 32776/data 0x102 held stable 4 cycles, all 8 words correct, done delayed 3 cycles.
REQ-035 num_regs 0 -> done in 1 cycle, no mem_we; num_regs 31 -> exactly 16 writes, output_reg 0..15.
REQ-036 clear_after 1, num_regs 2 -> reset_output one-cycle pulse after second accepted write, done next cycle; start during busy ignored.
REQ-037 rst_n low during 4th write -> mem_we low next cycle, no done; a subsequent start at base 0xFFFFFFF8, num_regs 3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/cim_result_writeback_if.sv
// RAM write port used by the CIM result writeback engine.
// The master drives the write request; the slave answers with mem_ready.
interface cim_result_writeback_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic        mem_ready;

    modport master (output mem_addr, mem_wdata, mem_we, mem_be, input mem_ready);
    modport slave  (input mem_addr, mem_wdata, mem_we, mem_be, output mem_ready);
endinterface

// File: rtl/cim_result_writeback.sv
// Copies a run of CIM output registers into consecutive RAM words.
// An optional CIM clear pulse follows the final write.
module cim_result_writeback #(
    parameter int CIM_LAT  = 1,
    parameter int MAX_REGS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [31:0]                   base_addr,
    input  logic [4:0]                    num_regs,
    input  logic                          clear_after,
    output logic                          busy,
    output logic                          done,
    output logic [3:0]                    output_reg,
    input  logic [31:0]                   cim_output,
    output logic                          reset_output,
    cim_result_writeback_if.master        mem
);

    typedef enum logic [2:0] {IDLE, SEL, WRITE, CLEAR, FIN} state_e;

    localparam logic [1:0] LAT_LAST = 2'(CIM_LAT - 1);
    localparam logic [4:0] MAX_CNT  = 5'(MAX_REGS);

    state_e      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [4:0]  count_q, count_d;
    logic        clr_q, clr_d;
    logic [4:0]  idx_q, idx_d;
    logic [1:0]  lat_q, lat_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic [4:0]  sat_cnt;
    logic [4:0]  nxt_idx;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        clr_d   = clr_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        sat_cnt = (num_regs > MAX_CNT) ? MAX_CNT : num_regs;
        nxt_idx = idx_q + 5'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    count_d = sat_cnt;
                    clr_d   = clear_after;
                    idx_d   = 5'd0;
                    lat_d   = 2'd0;
                    // An empty job leaves output_reg untouched and finishes at once.
                    if (sat_cnt == 5'd0) begin
                        state_d = FIN;
                    end else begin
                        sel_d   = 4'd0;
                        state_d = SEL;
                    end
                end
            end
            SEL: begin
                if (lat_q == LAT_LAST) begin
                    wdata_d = cim_output;
                    addr_d  = base_q + {25'd0, idx_q, 2'b00};
                    state_d = WRITE;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            WRITE: begin
                if (mem.mem_ready) begin
                    if (nxt_idx < count_q) begin
                        idx_d   = nxt_idx;
                        sel_d   = nxt_idx[3:0];
                        lat_d   = 2'd0;
                        state_d = SEL;
                    end else begin
                        state_d = clr_q ? CLEAR : FIN;
                    end
                end
            end
            CLEAR:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            clr_q   <= 1'b0;
            idx_q   <= '0;
            lat_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            clr_q   <= clr_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
        end
    end

    // Control outputs decode straight from the state so they are mutually exclusive.
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FIN);
    assign reset_output  = (state_q == CLEAR);
    assign output_reg    = sel_q;
    assign mem.mem_we    = (state_q == WRITE);
    assign mem.mem_be    = (state_q == WRITE) ? 4'b1111 : 4'b0000;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_cim_result_writeback.sv
// Randomized bench for cim_result_writeback with a job-level reference model.
module tb_cim_result_writeback;

    localparam int LAT = 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [4:0]  num_regs = '0;
    logic        clear_after = 1'b0;
    logic        busy, done, reset_output;
    logic [3:0]  output_reg;
    logic [31:0] cim_output;
    logic [31:0] tbl [16];

    cim_result_writeback_if mem_if ();

    cim_result_writeback #(.CIM_LAT(LAT), .MAX_REGS(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_regs(num_regs), .clear_after(clear_after), .busy(busy), .done(done),
        .output_reg(output_reg), .cim_output(cim_output),
        .reset_output(reset_output), .mem(mem_if)
    );

    always #5 clk = ~clk;
    assign cim_output = tbl[output_reg];

    int chk = 0;
    int err = 0;
    int cyc = 0;
    int done_seen = 0;
    int last_lat = 0;
    int clear_cnt = 0;
    int stall_left = 0;
    bit rand_ready = 0;
    wr_t wlog [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Job-level reference: expected word list, clear, and latency per accepted start.
    wr_t         exp_q [$];
    bit          job_active = 0;
    bit          exp_clr = 0;
    bit          clear_seen = 0;
    bit          rst_prev = 0;
    bit          stall_prev = 0;
    int          exp_cnt = 0;
    int          stalls = 0;
    int          start_cyc = 0;
    int          we_cyc = 0;
    logic [31:0] prev_addr, prev_data;

    always @(negedge clk) begin
        wr_t e;
        wr_t w;
        if (rst_prev) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_we", mem_if.mem_we, 0);
            check("rst_clear", reset_output, 0);
            check("rst_be", mem_if.mem_be, 0);
            check("rst_sel", output_reg, 0);
            check("rst_addr", mem_if.mem_addr, 0);
            check("rst_wdata", mem_if.mem_wdata, 0);
        end
        check("be_vs_we", mem_if.mem_be, mem_if.mem_we ? 32'hF : 32'h0);
        check("exclusive", (int'(mem_if.mem_we) + int'(reset_output) + int'(done)) <= 1, 1);
        check("busy", busy, job_active);
        if (stall_prev) begin
            check("hold_we", mem_if.mem_we, 1);
            check("hold_addr", mem_if.mem_addr, prev_addr);
            check("hold_data", mem_if.mem_wdata, prev_data);
        end
        stall_prev = 0;

        if (!rst_n) begin
            job_active = 0;
            exp_q.delete();
        end else begin
            if (mem_if.mem_we) begin
                we_cyc++;
                if (mem_if.mem_ready) begin
                    check("write_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("wr_addr", mem_if.mem_addr, e.addr);
                        check("wr_data", mem_if.mem_wdata, e.data);
                        check("wr_sel", output_reg, e.sel);
                    end
                    w.addr = mem_if.mem_addr;
                    w.data = mem_if.mem_wdata;
                    w.sel  = output_reg;
                    w.cyc  = we_cyc;
                    wlog.push_back(w);
                    we_cyc = 0;
                end else begin
                    stalls++;
                    stall_prev = 1;
                    prev_addr = mem_if.mem_addr;
                    prev_data = mem_if.mem_wdata;
                end
            end
            if (reset_output) begin
                clear_cnt++;
                check("clear_legal", job_active && exp_q.size() == 0 && exp_clr && !clear_seen, 1);
                clear_seen = 1;
            end
            if (done) begin
                last_lat = cyc - start_cyc + 1;
                check("done_in_job", job_active, 1);
                check("done_all_written", exp_q.size(), 0);
                check("done_clear", clear_seen, exp_clr);
                check("done_latency", last_lat, exp_cnt * (LAT + 1) + 1 + int'(exp_clr) + stalls);
                done_seen++;
                job_active = 0;
            end
            if (start && !busy) begin
                exp_cnt = (num_regs > 16) ? 16 : int'(num_regs);
                exp_q.delete();
                for (int i = 0; i < exp_cnt; i++) begin
                    e.addr = base_addr + 32'(4 * i);
                    e.data = tbl[i];
                    e.sel  = 4'(i);
                    e.cyc  = 0;
                    exp_q.push_back(e);
                end
                exp_clr    = clear_after && exp_cnt > 0;
                clear_seen = 0;
                stalls     = 0;
                we_cyc     = 0;
                start_cyc  = cyc + 1;
                job_active = 1;
            end
        end
        rst_prev = !rst_n;
    end

    initial begin
        mem_if.mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) mem_if.mem_ready = ($urandom_range(0, 3) != 0);
            else if (stall_left > 0 && mem_if.mem_we && wlog.size() == 2) begin
                mem_if.mem_ready = 1'b0;
                stall_left--;
            end else mem_if.mem_ready = 1'b1;
        end
    end

    task automatic pulse_start(input logic [31:0] b, input logic [4:0] n, input logic c);
        @(posedge clk);
        #1;
        base_addr = b;
        num_regs = n;
        clear_after = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int n = 0;
        while (done_seen == d0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        check(nm, done_seen != d0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [31:0] b, input logic [4:0] n, input logic c, input string nm);
        int d0 = done_seen;
        wlog.delete();
        pulse_start(b, n, c);
        wait_done(d0, nm);
    endtask

    initial begin
        int d0;
        int c0;
        for (int i = 0; i < 16; i++) tbl[i] = 32'h100 + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic eight-word job
        run_job(32768, 8, 0, "job8_done");
        check("job8_lat", last_lat, 17);
        check("job8_count", wlog.size(), 8);
        check("job8_first_addr", wlog[0].addr, 32768);
        check("job8_first_data", wlog[0].data, 32'h100);
        check("job8_last_addr", wlog[7].addr, 32796);
        check("job8_last_data", wlog[7].data, 32'h107);

        // Three-cycle stall on the third write
        stall_left = 3;
        run_job(32768, 8, 0, "stall_done");
        check("stall_lat", last_lat, 20);
        check("stall_count", wlog.size(), 8);
        check("stall_hold_cycles", wlog[2].cyc, 4);
        check("stall_addr", wlog[2].addr, 32776);
        check("stall_data", wlog[2].data, 32'h102);

        // Empty and saturated jobs
        c0 = clear_cnt;
        run_job(32'h40, 0, 1, "empty_done");
        check("empty_lat", last_lat, 1);
        check("empty_writes", wlog.size(), 0);
        check("empty_no_clear", clear_cnt, c0);
        run_job(32'h1000, 31, 0, "sat_done");
        check("sat_count", wlog.size(), 16);
        check("sat_last_sel", wlog[15].sel, 15);
        check("sat_lat", last_lat, 33);

        // Clear pulse plus an ignored start while busy
        c0 = clear_cnt;
        d0 = done_seen;
        wlog.delete();
        pulse_start(32'h200, 2, 1);
        base_addr = 32'h9000;
        num_regs = 5;
        clear_after = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d0, "clear_done");
        check("clear_lat", last_lat, 6);
        check("clear_pulses", clear_cnt - c0, 1);
        check("clear_writes", wlog.size(), 2);

        // Reset during the fourth write, then a wrapping job
        d0 = done_seen;
        wlog.delete();
        pulse_start(32'h4000, 8, 1);
        for (int n = 0; n < 100; n++) begin
            if (wlog.size() == 3 && mem_if.mem_we) break;
            @(posedge clk);
            #1;
        end
        check("abort_reached_4th", mem_if.mem_we, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_we_low", mem_if.mem_we, 0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", done_seen, d0);
        check("abort_writes", wlog.size(), 3);
        run_job(32'hFFFF_FFF8, 3, 0, "wrap_done");
        check("wrap_a0", wlog[0].addr, 32'hFFFF_FFF8);
        check("wrap_a1", wlog[1].addr, 32'hFFFF_FFFC);
        check("wrap_a2", wlog[2].addr, 32'h0000_0000);

        // Randomized jobs with random RAM backpressure
        rand_ready = 1;
        for (int j = 0; j < 30; j++) begin
            for (int i = 0; i < 16; i++) tbl[i] = $urandom;
            run_job($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "rand_done");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rand_ready = 0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
